// File: rtl/ball_game_engine.sv
// ball_game_engine: frame-rate game state for the breakout core.
// Owns the paddle, the ball position/velocity, the life count and the
// START -> PLAYING -> RESPAWN / GAME_OVER sequence. Collision side flags are
// latched between frame pulses and consumed on the pulse.
// Optional feature macro: PADDLE_ENGLISH_EN (zone-based vx on paddle hits).
module ball_game_engine #(
  parameter int FRAC_BITS      = 1,
  parameter int VEL_W          = 4,
  parameter int INITIAL_VEL_X  = 2,
  parameter int INITIAL_VEL_Y  = -2,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BORDER_WIDTH   = 8,
  parameter int PADDLE_WIDTH   = 99,
  parameter int PADDLE_SPEED   = 2,
  parameter int PADDLE_Y       = 452,
  parameter int BALL_SIZE      = 4,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60,
  localparam int LW            = $clog2(LIVES + 1)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          frame_pulse,
  input  logic          btn_action,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          collision,
  input  logic          ball_top_col,
  input  logic          ball_left_col,
  input  logic          ball_bottom_col,
  input  logic          ball_right_col,
  input  logic          paddle_col,
  output logic [9:0]    ball_x,
  output logic [8:0]    ball_y,
  output logic [9:0]    paddle_x,
  output logic [LW-1:0] lives,
  output logic [1:0]    game_state,
  output logic          game_over
);

  localparam int X_W = 11 + FRAC_BITS;
  localparam int Y_W = 10 + FRAC_BITS;
  localparam int CW  = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  localparam logic [9:0] INIT_PADDLE = 10'(SCREEN_W / 2 - PADDLE_WIDTH / 2 - 1);
  localparam logic [9:0] PADDLE_MIN  = 10'(BORDER_WIDTH);
  localparam logic [9:0] PADDLE_MAX  = 10'(SCREEN_W - BORDER_WIDTH - PADDLE_WIDTH);
  localparam logic [9:0] LEFT_LIMIT  = 10'(BORDER_WIDTH + PADDLE_SPEED);
  localparam logic [9:0] RIGHT_LIMIT = 10'(SCREEN_W - BORDER_WIDTH - PADDLE_WIDTH - PADDLE_SPEED);
  localparam logic [9:0] STEP        = 10'(PADDLE_SPEED);

  localparam logic [X_W-1:0] DOCK_OFF = X_W'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);
  localparam logic [X_W-1:0] RESET_X  = (X_W'(INIT_PADDLE) + DOCK_OFF) << FRAC_BITS;
  localparam logic [Y_W-1:0] DOCK_Y   = Y_W'((PADDLE_Y - BALL_SIZE) * (2 ** FRAC_BITS));

  localparam logic signed [VEL_W-1:0] VX0     = VEL_W'(INITIAL_VEL_X);
  localparam logic signed [VEL_W-1:0] VY0     = VEL_W'(INITIAL_VEL_Y);
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [10:0]      OOB_Y   = 11'(SCREEN_H);
  localparam logic [CW-1:0]           RESPAWN_LOAD = CW'(RESPAWN_FRAMES);
  localparam logic [LW-1:0]           LIVES_LOAD   = LW'(LIVES);

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t                  state_r, state_n;
  logic [LW-1:0]           lives_r, lives_n;
  logic [9:0]              paddle_r, paddle_n, paddle_move_s;
  logic [X_W-1:0]          pos_x_r, pos_x_n, dock_x_s;
  logic [Y_W-1:0]          pos_y_r, pos_y_n;
  logic signed [VEL_W-1:0] vel_x_r, vel_x_n, vx_s;
  logic signed [VEL_W-1:0] vel_y_r, vel_y_n, vy_s;
  logic [CW-1:0]           cnt_r, cnt_n;
  logic                    game_over_r, game_over_n;
  logic                    flag_top_r, flag_left_r, flag_bottom_r, flag_right_r, flag_paddle_r;
  logic                    flag_top_n, flag_left_n, flag_bottom_n, flag_right_n, flag_paddle_n;
  logic [9:0]              y_int_s;
  logic signed [10:0]      y_ext_s;
  logic                    oob_s;

  // Negation that saturates the most negative velocity instead of wrapping.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W-1:0] r;
    if (v == VEL_MIN) r = VEL_MAX;
    else              r = -v;
    return r;
  endfunction

  assign ball_x     = pos_x_r[FRAC_BITS+9:FRAC_BITS];
  assign ball_y     = pos_y_r[FRAC_BITS+8:FRAC_BITS];
  assign paddle_x   = paddle_r;
  assign lives      = lives_r;
  assign game_state = state_r;
  assign game_over  = game_over_r;

  assign y_int_s     = pos_y_r[Y_W-1:FRAC_BITS];
  assign y_ext_s     = {y_int_s[9], y_int_s};
  assign oob_s       = (y_ext_s >= OOB_Y);
  assign dock_x_s    = (X_W'(paddle_move_s) + DOCK_OFF) << FRAC_BITS;
  assign game_over_n = (state_n == ST_GAME_OVER);

`ifdef PADDLE_ENGLISH_EN
  localparam logic signed [11:0]      ZONE_LO = 12'(PADDLE_WIDTH / 3);
  localparam logic signed [11:0]      ZONE_HI = 12'(2 * PADDLE_WIDTH / 3);
  localparam logic signed [VEL_W-1:0] VX_POS  = VEL_W'((INITIAL_VEL_X < 0) ? -INITIAL_VEL_X : INITIAL_VEL_X);
  localparam logic signed [VEL_W-1:0] VX_NEG  = VEL_W'((INITIAL_VEL_X < 0) ? INITIAL_VEL_X : -INITIAL_VEL_X);
  logic signed [11:0] offset_s;
  assign offset_s = $signed(12'(ball_x) + 12'(BALL_SIZE / 2) - 12'(paddle_r));
`else
  logic unused_paddle_flag_s;
  assign unused_paddle_flag_s = flag_paddle_r;
`endif

  // Paddle step with exact wall clamps; left wins over right.
  always_comb begin
    if (btn_left) begin
      if (paddle_r >= LEFT_LIMIT) paddle_move_s = paddle_r - STEP;
      else                        paddle_move_s = PADDLE_MIN;
    end else if (btn_right) begin
      if (paddle_r <= RIGHT_LIMIT) paddle_move_s = paddle_r + STEP;
      else                         paddle_move_s = PADDLE_MAX;
    end else begin
      paddle_move_s = paddle_r;
    end
  end

  // Reflected velocity from the latched collision sides.
  always_comb begin
    if (flag_top_r || flag_bottom_r) vy_s = neg_sat(vel_y_r);
    else                             vy_s = vel_y_r;
    if (flag_left_r || flag_right_r) vx_s = neg_sat(vel_x_r);
    else                             vx_s = vel_x_r;
`ifdef PADDLE_ENGLISH_EN
    if (flag_paddle_r && flag_bottom_r) begin
      if (offset_s < ZONE_LO)       vx_s = VX_NEG;
      else if (offset_s >= ZONE_HI) vx_s = VX_POS;
      else                          vx_s = vel_x_r;
    end else begin
      vx_s = vx_s;
    end
`endif
  end

  // Sticky collision side flags; a frame pulse clears them and drops that cycle's sample.
  always_comb begin
    flag_top_n    = flag_top_r;
    flag_left_n   = flag_left_r;
    flag_bottom_n = flag_bottom_r;
    flag_right_n  = flag_right_r;
    flag_paddle_n = flag_paddle_r;
    if (frame_pulse) begin
      flag_top_n    = 1'b0;
      flag_left_n   = 1'b0;
      flag_bottom_n = 1'b0;
      flag_right_n  = 1'b0;
      flag_paddle_n = 1'b0;
    end else if (collision) begin
      flag_top_n    = flag_top_r    | ball_top_col;
      flag_left_n   = flag_left_r   | ball_left_col;
      flag_bottom_n = flag_bottom_r | ball_bottom_col;
      flag_right_n  = flag_right_r  | ball_right_col;
      flag_paddle_n = flag_paddle_r | paddle_col;
    end else begin
      flag_top_n = flag_top_r;
    end
  end

  // Game FSM next state plus per-frame paddle, ball, lives and respawn counter update.
  always_comb begin
    state_n = state_r;
    lives_n = lives_r;
    paddle_n = paddle_r;
    pos_x_n = pos_x_r;
    pos_y_n = pos_y_r;
    vel_x_n = vel_x_r;
    vel_y_n = vel_y_r;
    cnt_n   = cnt_r;
    if (frame_pulse) begin
      case (state_r)
        ST_START: begin
          paddle_n = paddle_move_s;
          pos_x_n  = dock_x_s;
          pos_y_n  = DOCK_Y;
          vel_x_n  = VX0;
          vel_y_n  = VY0;
          if (btn_action) state_n = ST_PLAYING;
          else            state_n = ST_START;
        end
        ST_PLAYING: begin
          paddle_n = paddle_move_s;
          if (oob_s) begin
            lives_n = lives_r - LW'(1);
            if (lives_r == LW'(1)) begin
              state_n = ST_GAME_OVER;
            end else begin
              state_n  = ST_RESPAWN;
              cnt_n    = RESPAWN_LOAD;
              paddle_n = INIT_PADDLE;
            end
          end else begin
            vel_x_n = vx_s;
            vel_y_n = vy_s;
            pos_x_n = pos_x_r + {{(X_W-VEL_W){vx_s[VEL_W-1]}}, vx_s};
            pos_y_n = pos_y_r + {{(Y_W-VEL_W){vy_s[VEL_W-1]}}, vy_s};
          end
        end
        ST_RESPAWN: begin
          paddle_n = paddle_move_s;
          pos_x_n  = dock_x_s;
          pos_y_n  = DOCK_Y;
          vel_x_n  = VX0;
          vel_y_n  = VY0;
          if (cnt_r <= CW'(1)) begin
            cnt_n   = {CW{1'b0}};
            state_n = ST_START;
          end else begin
            cnt_n = cnt_r - CW'(1);
          end
        end
        ST_GAME_OVER: begin
          if (btn_action) begin
            state_n  = ST_START;
            lives_n  = LIVES_LOAD;
            paddle_n = INIT_PADDLE;
          end else begin
            state_n = ST_GAME_OVER;
          end
        end
        default: state_n = ST_START;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_r       <= ST_START;
      lives_r       <= LIVES_LOAD;
      paddle_r      <= INIT_PADDLE;
      pos_x_r       <= RESET_X;
      pos_y_r       <= DOCK_Y;
      vel_x_r       <= VX0;
      vel_y_r       <= VY0;
      cnt_r         <= {CW{1'b0}};
      game_over_r   <= 1'b0;
      flag_top_r    <= 1'b0;
      flag_left_r   <= 1'b0;
      flag_bottom_r <= 1'b0;
      flag_right_r  <= 1'b0;
      flag_paddle_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      lives_r       <= lives_n;
      paddle_r      <= paddle_n;
      pos_x_r       <= pos_x_n;
      pos_y_r       <= pos_y_n;
      vel_x_r       <= vel_x_n;
      vel_y_r       <= vel_y_n;
      cnt_r         <= cnt_n;
      game_over_r   <= game_over_n;
      flag_top_r    <= flag_top_n;
      flag_left_r   <= flag_left_n;
      flag_bottom_r <= flag_bottom_n;
      flag_right_r  <= flag_right_n;
      flag_paddle_r <= flag_paddle_n;
    end
  end

endmodule

// File: tb/tb_ball_game_engine.sv
// Testbench for ball_game_engine: directed checks from the test plan followed
// by randomized play compared against an integer-arithmetic game model.
module tb_ball_game_engine;

  localparam int PMIN = 8;
  localparam int PMAX = 533;
  localparam int PINIT = 270;

  logic clk = 1'b0;
  logic nRst, frame_pulse, btn_action, btn_left, btn_right, collision;
  logic ball_top_col, ball_left_col, ball_bottom_col, ball_right_col, paddle_col;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [9:0] paddle_x;
  logic [1:0] lives;
  logic [1:0] game_state;
  logic       game_over;

  always #5 clk = ~clk;

  ball_game_engine dut (
    .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .btn_action(btn_action),
    .btn_left(btn_left), .btn_right(btn_right), .collision(collision),
    .ball_top_col(ball_top_col), .ball_left_col(ball_left_col),
    .ball_bottom_col(ball_bottom_col), .ball_right_col(ball_right_col),
    .paddle_col(paddle_col), .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
    .lives(lives), .game_state(game_state), .game_over(game_over)
  );

  int total = 0;
  int bad = 0;

  // model: positions in fractional units (1 px = 2 units)
  int m_px, m_bx, m_by, m_vx, m_vy, m_lives, m_st, m_cnt;
  bit m_ft, m_fl, m_fb, m_fr, m_fp;
  int cov_go = 0, cov_resp_done = 0, cov_coinc = 0, cov_vflip = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v, input int bits);
    int m;
    int r;
    m = 1 << bits;
    r = ((v % m) + m) % m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int negsat(input int v);
    return (v == -8) ? 7 : -v;
  endfunction

  task automatic model_reset();
    m_px = PINIT; m_bx = (PINIT + 47) * 2; m_by = 448 * 2;
    m_vx = 2; m_vy = -2; m_lives = 3; m_st = 0; m_cnt = 0;
    m_ft = 0; m_fl = 0; m_fb = 0; m_fr = 0; m_fp = 0;
  endtask

  task automatic dock();
    m_bx = (m_px + 47) * 2; m_by = 448 * 2; m_vx = 2; m_vy = -2;
  endtask

  task automatic model_frame(input bit act, input bit lf, input bit rt);
    int npx;
    int o;
    npx = m_px;
    if (lf) npx = (m_px - 2 < PMIN) ? PMIN : m_px - 2;
    else if (rt) npx = (m_px + 2 > PMAX) ? PMAX : m_px + 2;
    case (m_st)
      0: begin
        m_px = npx; dock();
        if (act) m_st = 1;
      end
      1: begin
        m_px = npx;
        if ((m_by >>> 1) >= 480) begin
          m_lives--;
          if (m_lives == 0) begin m_st = 3; cov_go++; end
          else begin m_st = 2; m_cnt = 60; m_px = PINIT; end
        end else begin
          o = ((m_bx >>> 1) & 1023) + 2 - m_px;
          if (m_ft || m_fb) begin m_vy = negsat(m_vy); cov_vflip++; end
          if (m_fl || m_fr) m_vx = negsat(m_vx);
`ifdef PADDLE_ENGLISH_EN
          if (m_fp && m_fb) begin
            if (o < 33) m_vx = -2;
            else if (o >= 66) m_vx = 2;
            else if (m_fl || m_fr) m_vx = negsat(m_vx);
          end
`endif
          m_bx = wrap(m_bx + m_vx, 12);
          m_by = wrap(m_by + m_vy, 11);
        end
      end
      2: begin
        m_px = npx; dock();
        if (m_cnt <= 1) begin m_cnt = 0; m_st = 0; cov_resp_done++; end
        else m_cnt--;
      end
      default: begin
        if (act) begin m_st = 0; m_lives = 3; m_px = PINIT; end
      end
    endcase
  endtask

  task automatic compare_all();
    check_value("ball_x", int'(ball_x), (m_bx >>> 1) & 1023);
    check_value("ball_y", int'(ball_y), (m_by >>> 1) & 511);
    check_value("paddle_x", int'(paddle_x), m_px);
    check_value("lives", int'(lives), m_lives);
    check_value("game_state", int'(game_state), m_st);
    check_value("game_over", int'(game_over), (m_st == 3) ? 1 : 0);
  endtask

  task automatic drive_cycle(input bit fp, input bit col, input bit t, input bit l,
                             input bit b, input bit r, input bit p,
                             input bit act, input bit lf, input bit rt);
    frame_pulse = fp; collision = col;
    ball_top_col = t; ball_left_col = l; ball_bottom_col = b; ball_right_col = r;
    paddle_col = p; btn_action = act; btn_left = lf; btn_right = rt;
    if (nRst) begin
      if (fp) begin
        if (col && m_st == 1) cov_coinc++;
        model_frame(act, lf, rt);
        m_ft = 0; m_fl = 0; m_fb = 0; m_fr = 0; m_fp = 0;
      end else if (col) begin
        m_ft |= t; m_fl |= l; m_fb |= b; m_fr |= r; m_fp |= p;
      end
    end
    @(posedge clk);
    #1;
    if (nRst && fp) compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic frame(input bit act, input bit lf, input bit rt);
    idle(2);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, act, lf, rt);
  endtask

  task automatic reset_checks(input string tag);
    check_value({tag, "_paddle"}, int'(paddle_x), 270);
    check_value({tag, "_bx"}, int'(ball_x), 317);
    check_value({tag, "_by"}, int'(ball_y), 448);
    check_value({tag, "_lives"}, int'(lives), 3);
    check_value({tag, "_state"}, int'(game_state), 0);
    check_value({tag, "_go"}, int'(game_over), 0);
  endtask

  initial begin
    bit col, t, l, b, r, p, act, lf, rt;
    int mode;
    nRst = 1'b0;
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    nRst = 1'b1;
    reset_checks("rst");

    // paddle tracking and clamps while docked
    for (int i = 0; i < 5; i++) frame(0, 0, 1);
    check_value("right5_paddle", int'(paddle_x), 280);
    check_value("right5_ball_x", int'(ball_x), 327);
    for (int i = 0; i < 140; i++) frame(0, 1, 0);
    check_value("clamp_left", int'(paddle_x), 8);
    frame(0, 1, 1);
    check_value("clamp_left_hold", int'(paddle_x), 8);
    for (int i = 0; i < 270; i++) frame(0, 0, 1);
    check_value("clamp_right", int'(paddle_x), 533);

    // reset mid-frame with pending collision and pulse
    idle(1);
    drive_cycle(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    nRst = 1'b0;
    drive_cycle(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    nRst = 1'b1;
    reset_checks("rst2");

    // launch, top reflection, corner, coincidence
    frame(1, 0, 0);
    check_value("launch_state", int'(game_state), 1);
    frame(0, 0, 0);
    check_value("launch_bx", int'(ball_x), 318);
    check_value("launch_by", int'(ball_y), 447);
    drive_cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0);
    check_value("top_by", int'(ball_y), 448);
    drive_cycle(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0);
    check_value("corner_bx", int'(ball_x), 318);
    check_value("corner_by", int'(ball_y), 447);
    idle(2);
    drive_cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 0);
    check_value("coinc_by", int'(ball_y), 445);

    // randomized play
    for (int f = 0; f < 1600; f++) begin
      mode = (f / 100) % 3;
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
        col = 0; t = 0; l = 0; b = 0; r = 0; p = 0;
        if (m_st == 1) begin
          if (m_vy < 0 && (m_by >>> 1) < 420 && $urandom_range(0, 5) == 0) begin
            col = 1; t = 1; l = ($urandom_range(0, 3) == 0);
          end else if ($urandom_range(0, 24) == 0) begin
            col = 1;
            l = $urandom_range(0, 1); r = ($urandom_range(0, 3) == 0);
            p = $urandom_range(0, 1);
            b = ((m_by >>> 1) < 300) && ($urandom_range(0, 1) == 1);
            t = (m_vy < 0) && ($urandom_range(0, 1) == 1);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          col = 1; t = $urandom_range(0, 1); l = $urandom_range(0, 1);
          b = $urandom_range(0, 1); r = $urandom_range(0, 1); p = $urandom_range(0, 1);
        end
        drive_cycle(0, col, t, l, b, r, p, 0, 0, 0);
      end
      col = ($urandom_range(0, 5) == 0);
      t = col; l = col && ($urandom_range(0, 1) == 1); b = 0; r = 0; p = 0;
      if (m_st == 0 || m_st == 3) act = ($urandom_range(0, 3) == 0);
      else act = ($urandom_range(0, 9) == 0);
      if (mode == 1) begin lf = 1; rt = 0; end
      else if (mode == 2) begin lf = 0; rt = 1; end
      else begin lf = ($urandom_range(0, 2) == 0); rt = ($urandom_range(0, 2) == 0); end
      drive_cycle(1, col, t, l, b, r, p, act, lf, rt);
    end

    check_value("seen_game_over", (cov_go > 0) ? 1 : 0, 1);
    check_value("seen_respawn_end", (cov_resp_done > 0) ? 1 : 0, 1);
    check_value("seen_coincidence", (cov_coinc > 0) ? 1 : 0, 1);
    check_value("seen_vflip", (cov_vflip > 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_game_engine.md
# ball_game_engine

Frame-rate game-state engine for the breakout core: owns paddle position, ball position and velocity, life count and the start/play/respawn/game-over sequence. It is the parametrised successor of the single-life ball/paddle logic. It adds configurable sub-pixel precision, velocity width and screen geometry, plus a lives counter, a respawn delay, a game-over state, corner reflection and clamped paddle limits. It sits between the input debouncer, the renderer's collision detector and the video sprite generators.

## Interface
- FRAC_BITS, 1: sub-pixel fraction bits of the ball position.
- VEL_W, 4: signed velocity width, in fractional units.
- INITIAL_VEL_X, 2 / INITIAL_VEL_Y, -2: launch velocity.
- SCREEN_W, 640 / SCREEN_H, 480: playfield size in pixels.
- BORDER_WIDTH, 8: side wall width.
- PADDLE_WIDTH, 99 / PADDLE_SPEED, 2 / PADDLE_Y, 452: paddle geometry and speed.
- BALL_SIZE, 4: ball edge length.
- LIVES, 3: lives per game; LW = $clog2(LIVES+1).
- RESPAWN_FRAMES, 60: pause after a lost life.

Ports:
- clk  in  1  system clock.
- nRst  in  1  reset; **one clock; reset is synchronous and active-low**.
- frame_pulse  in  1  one-cycle pulse once per frame.
- btn_action, btn_left, btn_right  in  1 each  debounced buttons.
- collision  in  1  ball pixel overlaps a solid object this cycle.
- ball_top_col, ball_left_col, ball_bottom_col, ball_right_col  in  1 each  ball side involved in the collision.
- paddle_col  in  1  the collided object is the paddle.
- ball_x  out  10  ball left edge, in pixels.
- ball_y  out  9  ball top edge, in pixels.
- paddle_x  out  10  paddle left edge.
- lives  out  LW  remaining lives.
- game_state  out  2  START=0, PLAYING=1, RESPAWN=2, GAME_OVER=3.
- game_over  out  1  high in GAME_OVER.

## Operation
- **Collision latches.** Between frame pulses, a cycle with `collision` high ORs each `*_col` and `paddle_col` into sticky flags. All flags clear on `frame_pulse`.
- All state below updates only on cycles where `frame_pulse` is high.
- **Paddle.** Moves in START, PLAYING and RESPAWN. Left has priority over right.
  - Left: paddle_x = max(paddle_x − PADDLE_SPEED, BORDER_WIDTH).
  - Right: paddle_x = min(paddle_x + PADDLE_SPEED, SCREEN_W − BORDER_WIDTH − PADDLE_WIDTH).
  - The clamp is exact; there is no half-step tolerance.
- **Ball position.**
  - Internal x is signed, 11+FRAC_BITS bits; internal y is signed, 10+FRAC_BITS bits.
  - The outputs are the integer part, truncated.
- **Docked ball (START and RESPAWN).**
  - x = new paddle_x + PADDLE_WIDTH/2 − BALL_SIZE/2; y = PADDLE_Y − BALL_SIZE; fraction bits are 0.
  - Velocity is held at its initial value.
- **START.** `btn_action` moves to PLAYING.
- **PLAYING.**
  - Out of bounds means integer y ≥ SCREEN_H.
  - On out of bounds, lives decrements. If the new value is 0, go to GAME_OVER. Otherwise go to RESPAWN, load the counter with RESPAWN_FRAMES and reset the paddle to INITIAL_PADDLE_X = SCREEN_W/2 − PADDLE_WIDTH/2 − 1.
  - Otherwise, for the velocity:
    - vy is negated if the top or bottom flag is set.
    - vx is negated if the left or right flag is set.
    - Both are negated on a corner hit.
  - Then pos += new velocity, using sign-extended addition.
  - Negating −2^(VEL_W−1) saturates to 2^(VEL_W−1)−1.
- **RESPAWN.** The counter decrements each frame; at 0 go to START.
- **GAME_OVER.** Ball and paddle are frozen. `btn_action` moves to START, reloads lives=LIVES and resets the paddle.

## Timing
- Reset values, applied on the clk edge with nRst low:
  - game_state=0, lives=LIVES, game_over=0, all flags 0.
  - paddle_x=270, ball_x=317, ball_y=448 (FRAC zeros).
  - Velocity is the initial value.
- All outputs are registered. Updates are visible the cycle after the `frame_pulse` edge, so latency is 1 clk.
- If `collision` coincides with `frame_pulse`, the flags clear and that collision sample is dropped.
- Reset asserted mid-frame discards the latches and the respawn count.

## Configuration
- `PADDLE_ENGLISH_EN` defined: on a frame with both the paddle and bottom flags set, vx is replaced by a zone value instead of being kept or negated. The ball centre offset o = ball_x + BALL_SIZE/2 − paddle_x selects the zone:
  - o < PADDLE_WIDTH/3: vx = −|INITIAL_VEL_X|.
  - o ≥ 2·PADDLE_WIDTH/3: vx = +|INITIAL_VEL_X|.
  - Otherwise vx keeps its sign.
  - vy is still negated.
- Undefined: `paddle_col` is latched but ignored; the paddle reflects like any other object.

## Test plan
- **Reset.** Hold nRst low for 2 clk → paddle_x=270, ball (317,448), lives=3, game_state=0, game_over=0.
- **Paddle tracking and clamp.** In START, hold btn_right for 5 frames → paddle_x=280, ball_x=327. Force paddle_x=9 and press btn_left → paddle_x=8, then stays 8.
- **Launch.** btn_action on a frame → state 1. Next frame → ball (318,447), since 2 fractional units equal 1 pixel.
- **Top and corner reflection.** A mid-frame collision with top_col → vy=+2 and ball_y +1 px that frame. Top+left together → both components negated.
- **Lives.** Drive ball_y to 480 → lives=2, state 2; 60 frames later → state 0. The third loss → state 3, game_over=1. btn_action → state 0, lives=3, paddle_x=270.
- **Collision/frame coincidence.** `collision` in the same cycle as `frame_pulse` → no reflection on the following frame.
